// File: rtl/projetil_lancado.sv
// projetil_lancado: one shot slot. It takes a launch command carrying a start
// position, then flies a round projectile vertically at a fixed pixel rate.
// The shot retires when it is hit or when it leaves the screen.
//
// Ports:
//   CLOCK_50   system clock
//   resetNave  asynchronous, active-high reset
//   pausa      1 = freeze movement and ignore launches (acerto still honoured)
//   iniciar    launch request; only its rising edge counts as a command
//   xi, yi     launch centre position (10-bit, passed through unchecked)
//   ehAliada   1 = flies up (y decreasing), 0 = flies down
//   acerto     hit report from collision logic; retires the shot
//   x, y       current centre (FORA while inactive)
//   raio       projectile radius (constant RAIO)
//   ativa      1 while in flight
//   pronta     1 when a launch edge will be accepted
//   lancou     1-cycle acknowledge of an accepted launch
//   terminou   1-cycle pulse when the shot retires
module projetil_lancado #(
    parameter int unsigned DIV      = 250000,
    parameter int unsigned PASSO    = 1,
    parameter int unsigned RAIO     = 5,
    parameter int unsigned TELA_ALT = 480,
    parameter int unsigned FORA     = 1000
) (
    input  logic       CLOCK_50,
    input  logic       resetNave,
    input  logic       pausa,
    input  logic       iniciar,
    input  logic [9:0] xi,
    input  logic [9:0] yi,
    input  logic       ehAliada,
    input  logic       acerto,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [9:0] raio,
    output logic       ativa,
    output logic       pronta,
    output logic       lancou,
    output logic       terminou
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        OCIOSA = 2'd0,
        VOO    = 2'd1,
        FIM    = 2'd2
    } estado_t;

    estado_t          estado;
    logic [CNT_W-1:0] cnt;
    logic             iniciar_d;

    logic             borda;
    logic             passo_agora;
    logic [10:0]      y_soma;
    logic             saiu_tela;
    logic             retira;
    logic             avanca;

    // Launch command is the rising edge of iniciar, tracked even while paused
    assign borda = iniciar & ~iniciar_d;

    // Movement step fires on the last count of the divider
    assign passo_agora = (cnt == CNT_W'(DIV - 1));

    // Enemy exit check done in 11 bits so y+PASSO cannot wrap
    assign y_soma = {1'b0, y} + 11'(PASSO);

    // A step would carry the shot off screen (no wrap below 0 going up)
    always_comb begin
        saiu_tela = 1'b0;
        if (ehAliada) begin
            saiu_tela = (y < 10'(PASSO));
        end else begin
            saiu_tela = (y_soma >= 11'(TELA_ALT));
        end
    end

    // Retire on a hit (priority, even when paused) or on leaving the screen
    always_comb begin
        retira = 1'b0;
        avanca = 1'b0;
        if (estado == VOO) begin
            if (acerto) begin
                retira = 1'b1;
            end else if (!pausa && passo_agora) begin
                retira = saiu_tela;
                avanca = ~saiu_tela;
            end
        end
    end

    // State machine with registered outputs
    always_ff @(posedge CLOCK_50 or posedge resetNave) begin
        if (resetNave) begin
            estado    <= OCIOSA;
            cnt       <= '0;
            iniciar_d <= 1'b0;
            x         <= 10'(FORA);
            y         <= 10'(FORA);
            raio      <= 10'(RAIO);
            ativa     <= 1'b0;
            pronta    <= 1'b1;
            lancou    <= 1'b0;
            terminou  <= 1'b0;
        end else begin
            iniciar_d <= iniciar;
            raio      <= 10'(RAIO);
            lancou    <= 1'b0;
            terminou  <= 1'b0;

            case (estado)
                OCIOSA: begin
                    pronta <= 1'b1;
                    ativa  <= 1'b0;
                    x      <= 10'(FORA);
                    y      <= 10'(FORA);
                    if (borda && !pausa) begin
                        x      <= xi;
                        y      <= yi;
                        cnt    <= '0;
                        lancou <= 1'b1;
                        pronta <= 1'b0;
                        ativa  <= 1'b1;
                        estado <= VOO;
                    end
                end

                VOO: begin
                    if (retira) begin
                        terminou <= 1'b1;
                        ativa    <= 1'b0;
                        x        <= 10'(FORA);
                        y        <= 10'(FORA);
                        estado   <= FIM;
                    end else if (!pausa) begin
                        if (passo_agora) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (avanca) begin
                            if (ehAliada) begin
                                y <= y - 10'(PASSO);
                            end else begin
                                y <= y + 10'(PASSO);
                            end
                        end
                    end
                end

                FIM: begin
                    // pronta rises the cycle after the terminou pulse
                    pronta <= 1'b1;
                    estado <= OCIOSA;
                end

                default: begin
                    estado <= OCIOSA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_projetil_lancado.sv
// Directed bench for projetil_lancado with DIV=4. Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_projetil_lancado;

    logic       CLOCK_50;
    logic       resetNave;
    logic       pausa;
    logic       iniciar;
    logic [9:0] xi;
    logic [9:0] yi;
    logic       ehAliada;
    logic       acerto;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] raio;
    logic       ativa;
    logic       pronta;
    logic       lancou;
    logic       terminou;

    int n_checks = 0;
    int n_fails  = 0;

    projetil_lancado #(
        .DIV      (4),
        .PASSO    (1),
        .RAIO     (5),
        .TELA_ALT (480),
        .FORA     (1000)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetNave (resetNave),
        .pausa     (pausa),
        .iniciar   (iniciar),
        .xi        (xi),
        .yi        (yi),
        .ehAliada  (ehAliada),
        .acerto    (acerto),
        .x         (x),
        .y         (y),
        .raio      (raio),
        .ativa     (ativa),
        .pronta    (pronta),
        .lancou    (lancou),
        .terminou  (terminou)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        resetNave = 1'b1;
        pausa     = 1'b0;
        iniciar   = 1'b0;
        xi        = '0;
        yi        = '0;
        ehAliada  = 1'b1;
        acerto    = 1'b0;
        ciclos(2);
        resetNave = 1'b0;

        // Reset state and idle hold
        check_eq("rst_x", 32'(x), 1000);
        check_eq("rst_y", 32'(y), 1000);
        check_eq("rst_raio", 32'(raio), 5);
        check_eq("rst_pronta", 32'(pronta), 1);
        check_eq("rst_ativa", 32'(ativa), 0);
        check_eq("rst_lancou", 32'(lancou), 0);
        check_eq("rst_terminou", 32'(terminou), 0);
        ciclos(20);
        check_eq("idle_y", 32'(y), 1000);
        check_eq("idle_pronta", 32'(pronta), 1);
        check_eq("idle_ativa", 32'(ativa), 0);

        // Ally launch 365,420
        xi = 10'd365; yi = 10'd420; ehAliada = 1'b1; iniciar = 1'b1;
        ciclos(1);
        check_eq("l1_lancou", 32'(lancou), 1);
        check_eq("l1_ativa", 32'(ativa), 1);
        check_eq("l1_pronta", 32'(pronta), 0);
        check_eq("l1_x", 32'(x), 365);
        check_eq("l1_y", 32'(y), 420);
        ciclos(1);
        check_eq("l1_lancou_pulse", 32'(lancou), 0);
        ciclos(2);
        check_eq("l1_y_before_step", 32'(y), 420);
        ciclos(1);
        check_eq("l1_y_4", 32'(y), 419);
        ciclos(36);
        check_eq("l1_y_40", 32'(y), 410);
        check_eq("l1_x_const", 32'(x), 365);
        acerto = 1'b1;
        ciclos(1);
        acerto = 1'b0;
        check_eq("l1_hit_terminou", 32'(terminou), 1);
        check_eq("l1_hit_ativa", 32'(ativa), 0);
        check_eq("l1_hit_x", 32'(x), 1000);
        check_eq("l1_hit_pronta", 32'(pronta), 0);
        ciclos(1);
        check_eq("l1_fim_terminou", 32'(terminou), 0);
        check_eq("l1_fim_pronta", 32'(pronta), 1);
        // iniciar still high: no relaunch
        ciclos(10);
        check_eq("held_no_relaunch", 32'(ativa), 0);
        check_eq("held_y", 32'(y), 1000);

        // Ally near top: 2,1,0 then exit
        iniciar = 1'b0;
        ciclos(1);
        xi = 10'd100; yi = 10'd2; iniciar = 1'b1;
        ciclos(1);
        check_eq("top_y2", 32'(y), 2);
        ciclos(4);
        check_eq("top_y1", 32'(y), 1);
        ciclos(4);
        check_eq("top_y0", 32'(y), 0);
        ciclos(3);
        check_eq("top_y0_hold", 32'(y), 0);
        check_eq("top_ativa_hold", 32'(ativa), 1);
        ciclos(1);
        check_eq("top_terminou", 32'(terminou), 1);
        check_eq("top_x", 32'(x), 1000);
        check_eq("top_y", 32'(y), 1000);
        ciclos(1);
        check_eq("top_terminou_pulse", 32'(terminou), 0);
        check_eq("top_pronta", 32'(pronta), 1);

        // Enemy near bottom: 477,478,479 then exit
        iniciar = 1'b0;
        ciclos(1);
        xi = 10'd50; yi = 10'd477; ehAliada = 1'b0; iniciar = 1'b1;
        ciclos(1);
        check_eq("bot_y477", 32'(y), 477);
        ciclos(4);
        check_eq("bot_y478", 32'(y), 478);
        ciclos(4);
        check_eq("bot_y479", 32'(y), 479);
        ciclos(3);
        check_eq("bot_y479_hold", 32'(y), 479);
        ciclos(1);
        check_eq("bot_terminou", 32'(terminou), 1);
        check_eq("bot_y_park", 32'(y), 1000);
        // Edge in the cycle right after FIM is accepted
        iniciar = 1'b0;
        ciclos(1);
        check_eq("bot_pronta", 32'(pronta), 1);
        xi = 10'd200; yi = 10'd300; ehAliada = 1'b1; iniciar = 1'b1;
        ciclos(1);
        check_eq("quick_lancou", 32'(lancou), 1);
        check_eq("quick_y", 32'(y), 300);

        // Second edge mid-flight is ignored
        iniciar = 1'b0;
        ciclos(1);
        xi = 10'd10; yi = 10'd10; iniciar = 1'b1;
        ciclos(1);
        check_eq("mid_edge_lancou", 32'(lancou), 0);
        check_eq("mid_edge_x", 32'(x), 200);
        check_eq("mid_edge_y", 32'(y), 300);
        ciclos(2);
        check_eq("mid_y299", 32'(y), 299);

        // Pause holds position; hit during pause still retires
        pausa = 1'b1;
        ciclos(10);
        check_eq("pause_y", 32'(y), 299);
        check_eq("pause_ativa", 32'(ativa), 1);
        acerto = 1'b1;
        ciclos(1);
        acerto = 1'b0;
        check_eq("pause_hit_terminou", 32'(terminou), 1);
        check_eq("pause_hit_ativa", 32'(ativa), 0);
        ciclos(1);
        check_eq("pause_hit_pronta", 32'(pronta), 1);

        // Edge while paused in idle is lost
        iniciar = 1'b0;
        ciclos(1);
        iniciar = 1'b1;
        ciclos(1);
        check_eq("pause_launch_lancou", 32'(lancou), 0);
        check_eq("pause_launch_ativa", 32'(ativa), 0);
        pausa = 1'b0;
        ciclos(2);
        check_eq("pause_launch_lost", 32'(ativa), 0);

        // Drop and re-raise relaunches; reset mid-flight parks at once
        iniciar = 1'b0;
        ciclos(1);
        xi = 10'd123; yi = 10'd200; iniciar = 1'b1;
        ciclos(1);
        check_eq("relaunch_lancou", 32'(lancou), 1);
        ciclos(5);
        check_eq("relaunch_y", 32'(y), 199);
        resetNave = 1'b1;
        iniciar   = 1'b0;
        #1;
        check_eq("async_rst_ativa", 32'(ativa), 0);
        check_eq("async_rst_x", 32'(x), 1000);
        check_eq("async_rst_y", 32'(y), 1000);
        check_eq("async_rst_pronta", 32'(pronta), 1);
        ciclos(1);
        resetNave = 1'b0;
        ciclos(2);
        check_eq("post_rst_ativa", 32'(ativa), 0);
        check_eq("post_rst_pronta", 32'(pronta), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
